mem_bus_arbiter: RTL and testbench
==================================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, meaning number of CPU requesters (2..8).
REQ-002 Parameter ADDR_W, default 32, meaning address width.
REQ-003 Parameter DATA_W, default 32, meaning data width.
REQ-004 Parameter TMO, default 255, meaning memory-ack timeout in cycles (1..255).
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 req_rd  input  N_REQ  per-requester read request, level, held until done.
REQ-008 req_wr  input  N_REQ  per-requester write request, level, held until done.
REQ-009 req_addr  input  N_REQ*ADDR_W  packed addresses; requester i at bits [i*ADDR_W +: ADDR_W].
REQ-010 req_wdata  input  N_REQ*DATA_W  packed write data, same packing.
REQ-011 gnt  output  N_REQ  one-hot grant of the current owner, all-zero when idle.
REQ-012 rd_dn  output  N_REQ  one-cycle read-complete pulse to the owner.
REQ-013 wr_dn  output  N_REQ  one-cycle write-complete pulse to the owner.
REQ-014 err  output  1  one-cycle pulse coincident with rd_dn/wr_dn when the access timed out.
REQ-015 rdata  output  DATA_W  read data, valid in the rd_dn cycle, held until the next read completes.
REQ-016 mem_rd, mem_wr  output  1 each  memory strobes, mutually exclusive.
REQ-017 mem_addr, mem_wdata  output  ADDR_W, DATA_W  latched address and write data.
REQ-018 mem_ack  input  1  memory completion, sampled only while a strobe is high.
REQ-019 mem_rdata  input  DATA_W  memory read data, valid with mem_ack.
REQ-020 bus_busy  output  1  high whenever state is not IDLE.

Function
REQ-021 FSM states: IDLE, ACCESS, DONE.
REQ-022 IDLE: if any req_rd|req_wr bit is set, the arbiter SHALL select the first requesting index searching from (ptr+1) mod N_REQ upward with wrap, latch index, op, address and data, set gnt, set ptr to the selected index, and enter ACCESS.
REQ-023 If the selected requester has both req_rd and req_wr set, the arbiter SHALL perform the read; the write stays pending for a later arbitration.
REQ-024 ACCESS: mem_rd or mem_wr SHALL stay high together with the stable mem_addr/mem_wdata; the timeout counter SHALL clear on entry and increment each cycle.
REQ-025 ACCESS: when mem_ack is sampled high, the arbiter SHALL capture mem_rdata into rdata (reads only), drop the strobe, and enter DONE.
REQ-026 ACCESS: when the counter reaches TMO without mem_ack, the arbiter SHALL drop the strobe, leave rdata unchanged, flag err, and enter DONE.
REQ-027 DONE: the arbiter SHALL pulse rd_dn[idx] or wr_dn[idx] (plus err if flagged) for exactly one cycle, then clear gnt and return to IDLE.
REQ-028 Latency: with the request seen at edge k and mem_ack high at edge k+1, the dn pulse SHALL be high during the cycle after edge k+2; minimum request-to-done is 3 cycles.
REQ-029 Requester changes to req_addr, req_wdata or req_* bits after latching SHALL NOT affect the in-flight access; a requester dropping its request mid-access SHALL still receive its dn pulse.
REQ-030 At most one access SHALL be in flight; gnt SHALL have at most one bit set.
REQ-031 Fairness: a continuously requesting requester SHALL be granted within N_REQ arbitrations.

Reset
REQ-032 When rst is high at an edge, the block SHALL force state IDLE, ptr=N_REQ-1, gnt=0, rd_dn=0, wr_dn=0, err=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0, rdata=0, and counter=0; bus_busy follows as 0.
REQ-033 Reset during ACCESS or DONE SHALL abort the access with no dn pulse; the aborted requester SHALL NOT be credited in ptr.

Verification
REQ-034 After reset, req_rd[0]=1 with addr 0x10, mem_ack one cycle later with mem_rdata 0xDEADBEEF -> gnt=0001, mem_rd=1, mem_addr=0x10, then rd_dn[0] for one cycle with rdata=0xDEADBEEF.
REQ-035 req_wr all four requesters held, mem_ack on every access -> grant order 0,1,2,3,0, one wr_dn per grant, mem_wdata matching each requester.
REQ-036 Requester 2 sets req_rd and req_wr together -> read performed first (mem_rd=1, rd_dn[2]), write performed on the next grant to 2.
REQ-037 mem_ack held low, TMO=4 -> mem_rd high for 4 cycles, then rd_dn and err pulse together, rdata unchanged.
REQ-038 rst asserted in the second ACCESS cycle -> next cycle all outputs at reset values, no dn pulse; a following req_rd[1] is granted first.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Round-robin arbiter that shares one single-outstanding memory port among
//   N_REQ CPU requesters. A winner is chosen in IDLE, its address, data and
//   operation are latched, the memory strobe is held in ACCESS until mem_ack
//   or the timeout, and a one-cycle done pulse is issued from DONE.
// Ports
//   clk, rst             : rising-edge clock, synchronous active-high reset
//   req_rd, req_wr       : per-requester level requests, held until done
//   req_addr, req_wdata  : packed per-requester address / write data
//   gnt                  : one-hot owner, all-zero when nobody owns the bus
//   rd_dn, wr_dn, err    : one-cycle completion pulses (err marks a timeout)
//   rdata                : last completed read data
//   mem_rd, mem_wr       : memory strobes, never both high
//   mem_addr, mem_wdata  : latched address / write data of the access
//   mem_ack, mem_rdata   : memory completion and read data
//   bus_busy             : high while an access is being sequenced
module mem_bus_arbiter #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int TMO    = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_rd,
    input  logic [N_REQ-1:0]        req_wr,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*DATA_W-1:0] req_wdata,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        rd_dn,
    output logic [N_REQ-1:0]        wr_dn,
    output logic                    err,
    output logic [DATA_W-1:0]       rdata,
    output logic                    mem_rd,
    output logic                    mem_wr,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    input  logic                    mem_ack,
    input  logic [DATA_W-1:0]       mem_rdata,
    output logic                    bus_busy
);

    localparam int IDX_W = $clog2(N_REQ);
    // The counter holds cycles already spent in ACCESS, so the last allowed
    // cycle is reached when it equals TMO-1.
    localparam logic [7:0] TMO_LAST = 8'(TMO - 1);
    localparam logic [N_REQ-1:0] ONE_HOT_LSB = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                is_rd_q, is_rd_d;
    logic                tmo_hit_q, tmo_hit_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [N_REQ-1:0]    gnt_q, gnt_d;
    logic [N_REQ-1:0]    rd_dn_q, rd_dn_d;
    logic [N_REQ-1:0]    wr_dn_q, wr_dn_d;
    logic                err_q, err_d;
    logic                mem_rd_q, mem_rd_d;
    logic                mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                bus_busy_q, bus_busy_d;

    logic [N_REQ-1:0]    req_any_s;
    logic                found_s;
    logic [IDX_W-1:0]    sel_s;

    assign req_any_s = req_rd | req_wr;

    // Round-robin pick: first requester above ptr, otherwise wrap to the lowest one.
    always_comb begin
        found_s = 1'b0;
        sel_s   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found_s && req_any_s[i] && (i > int'(ptr_q))) begin
                found_s = 1'b1;
                sel_s   = IDX_W'(i);
            end else begin
                found_s = found_s;
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!found_s && req_any_s[i] && (i <= int'(ptr_q))) begin
                found_s = 1'b1;
                sel_s   = IDX_W'(i);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next-state and next-output computation for the IDLE/ACCESS/DONE sequencer.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        idx_d       = idx_q;
        is_rd_d     = is_rd_q;
        tmo_hit_d   = tmo_hit_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt_q;
        rd_dn_d     = '0;
        wr_dn_d     = '0;
        err_d       = 1'b0;
        mem_rd_d    = mem_rd_q;
        mem_wr_d    = mem_wr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (found_s) begin
                    // A requester with both bits set gets its read first; the
                    // write bit stays up and wins a later arbitration.
                    state_d     = ST_ACCESS;
                    ptr_d       = sel_s;
                    idx_d       = sel_s;
                    is_rd_d     = req_rd[sel_s];
                    gnt_d       = ONE_HOT_LSB << sel_s;
                    mem_rd_d    = req_rd[sel_s];
                    mem_wr_d    = ~req_rd[sel_s];
                    mem_addr_d  = req_addr[sel_s*ADDR_W +: ADDR_W];
                    mem_wdata_d = req_wdata[sel_s*DATA_W +: DATA_W];
                    cnt_d       = 8'd0;
                    tmo_hit_d   = 1'b0;
                end else begin
                    // gnt stays up through the done-pulse cycle, then clears here.
                    gnt_d = '0;
                end
            end
            ST_ACCESS: begin
                if (mem_ack) begin
                    mem_rd_d = 1'b0;
                    mem_wr_d = 1'b0;
                    state_d  = ST_DONE;
                    if (is_rd_q) begin
                        rdata_d = mem_rdata;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else if (cnt_q == TMO_LAST) begin
                    mem_rd_d  = 1'b0;
                    mem_wr_d  = 1'b0;
                    tmo_hit_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                rd_dn_d[idx_q] = is_rd_q;
                wr_dn_d[idx_q] = ~is_rd_q;
                err_d          = tmo_hit_q;
                state_d        = ST_IDLE;
            end
            default: begin
                state_d  = ST_IDLE;
                gnt_d    = '0;
                mem_rd_d = 1'b0;
                mem_wr_d = 1'b0;
            end
        endcase
        bus_busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= IDX_W'(N_REQ - 1);
            idx_q       <= '0;
            is_rd_q     <= 1'b0;
            tmo_hit_q   <= 1'b0;
            cnt_q       <= 8'd0;
            gnt_q       <= '0;
            rd_dn_q     <= '0;
            wr_dn_q     <= '0;
            err_q       <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            bus_busy_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            idx_q       <= idx_d;
            is_rd_q     <= is_rd_d;
            tmo_hit_q   <= tmo_hit_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            rd_dn_q     <= rd_dn_d;
            wr_dn_q     <= wr_dn_d;
            err_q       <= err_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            bus_busy_q  <= bus_busy_d;
        end
    end

    assign gnt       = gnt_q;
    assign rd_dn     = rd_dn_q;
    assign wr_dn     = wr_dn_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign bus_busy  = bus_busy_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: a transaction-timeline model (grant edge,
// completion edge, pulse edge) predicts every output each cycle, and directed
// scenarios add hand-computed literal expectations.
module tb_mem_bus_arbiter;
    localparam int N   = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_rd, req_wr;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    gnt, rd_dn, wr_dn;
    logic            err, mem_rd, mem_wr, mem_ack, bus_busy;
    logic [DW-1:0]   rdata, mem_wdata, mem_rdata;
    logic [AW-1:0]   mem_addr;

    int n_cmp = 0;
    int n_bad = 0;

    // responder / requester controls
    logic          ack_en;
    int            ack_dly;
    int            strobe_cnt;
    logic [DW-1:0] rd_val;
    logic          auto_rel;
    logic          model_on;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TMO(TMO)) dut (
        .clk(clk), .rst(rst), .req_rd(req_rd), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt),
        .rd_dn(rd_dn), .wr_dn(wr_dn), .err(err), .rdata(rdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .bus_busy(bus_busy)
    );

    // Model: one access described by its grant edge k and completion edge e.
    // Strobe during cycles after edges k..e-1, busy k..e, done pulse after e+1,
    // owner kept until the next arbitration at edge e+2.
    typedef struct {
        int      own;
        int      ptr;
        int      k;
        int      e;
        int      now;
        bit      ended;
        bit      rd;
        bit      tmo;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdat;
    } mstate_t;

    mstate_t ms;

    function automatic mstate_t model_next(input mstate_t s);
        mstate_t n = s;
        bit found = 1'b0;
        int c;
        if (rst) begin
            n.own = -1; n.ptr = N - 1; n.k = 0; n.e = 0; n.now = 0;
            n.ended = 1'b0; n.rd = 1'b0; n.tmo = 1'b0;
            n.addr = '0; n.wdata = '0; n.rdat = '0;
            return n;
        end
        n.now = s.now + 1;
        if (n.own >= 0 && n.ended && n.now >= n.e + 2) n.own = -1;
        if (n.own >= 0 && !n.ended) begin
            if (mem_ack) begin
                n.ended = 1'b1; n.e = n.now;
                if (n.rd) n.rdat = mem_rdata;
            end else if (n.now - n.k == TMO) begin
                n.ended = 1'b1; n.e = n.now; n.tmo = 1'b1;
            end
        end else if (n.own < 0) begin
            for (int j = 1; j <= N; j++) begin
                c = (n.ptr + j) % N;
                if (!found && (req_rd[c] || req_wr[c])) begin
                    found = 1'b1;
                    n.own = c; n.ptr = c; n.k = n.now;
                    n.ended = 1'b0; n.tmo = 1'b0; n.rd = req_rd[c];
                    n.addr  = req_addr[c*AW +: AW];
                    n.wdata = req_wdata[c*DW +: DW];
                end
            end
        end
        return n;
    endfunction

    always @(posedge clk) ms <= model_next(ms);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One cycle: compare against the model at the falling edge, then act as
    // memory and as requesters for the next rising edge.
    task automatic step();
        logic [N-1:0] eg, erd, ewr;
        logic dn, busy;
        @(negedge clk);
        if (model_on) begin
            eg = '0; erd = '0; ewr = '0;
            if (ms.own >= 0) eg[ms.own] = 1'b1;
            dn   = (ms.own >= 0) && ms.ended && (ms.now == ms.e + 1);
            busy = (ms.own >= 0) && (!ms.ended || ms.now == ms.e);
            if (dn && ms.rd)  erd = eg;
            if (dn && !ms.rd) ewr = eg;
            chk("m_gnt", gnt, eg);
            chk("m_rd_dn", rd_dn, erd);
            chk("m_wr_dn", wr_dn, ewr);
            chk("m_err", err, dn && ms.tmo);
            chk("m_mem_rd", mem_rd, (ms.own >= 0) && !ms.ended && ms.rd);
            chk("m_mem_wr", mem_wr, (ms.own >= 0) && !ms.ended && !ms.rd);
            chk("m_busy", bus_busy, busy);
            chk("m_rdata", rdata, ms.rdat);
            chk("m_mem_addr", mem_addr, ms.addr);
            chk("m_mem_wdata", mem_wdata, ms.wdata);
        end
        if (mem_rd || mem_wr) begin
            strobe_cnt++;
            mem_ack = ack_en && (strobe_cnt >= ack_dly);
        end else begin
            strobe_cnt = 0;
            mem_ack = 1'b0;
        end
        mem_rdata = rd_val;
        if (auto_rel) begin
            req_rd = req_rd & ~rd_dn;
            req_wr = req_wr & ~wr_dn;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; req_rd = '0; req_wr = '0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic set_slot(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic wait_dn(output int cyc);
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (((rd_dn | wr_dn) == '0) && cyc < 40);
        chk("wait_dn_bound", cyc >= 40, 1'b0);
    endtask

    logic [N-1:0]  g_seen [5];
    logic [DW-1:0] w_seen [5];
    logic [N-1:0]  exp_g  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [DW-1:0] exp_w  [5] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333,
                                  32'h4444_4444, 32'h1111_1111};

    initial begin
        int cyc, ng, ndn, nhigh;
        logic [N-1:0] last_g;
        logic done;
        rst = 1'b1; req_rd = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0; ack_en = 1'b1; ack_dly = 1;
        strobe_cnt = 0; rd_val = '0; auto_rel = 1'b1; model_on = 1'b0;
        step(); step();
        model_on = 1'b1;
        do_reset();
        chk("rst_gnt", gnt, 4'b0000);
        chk("rst_busy", bus_busy, 1'b0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_mem_rd", mem_rd, 1'b0);

        // single read from requester 0, ack one cycle after the strobe
        set_slot(0, 32'h10, 32'h0);
        rd_val = 32'hDEAD_BEEF;
        req_rd[0] = 1'b1;
        step();
        chk("t1_gnt", gnt, 4'b0001);
        chk("t1_mem_rd", mem_rd, 1'b1);
        chk("t1_mem_addr", mem_addr, 32'h10);
        wait_dn(cyc);
        chk("t1_latency", cyc, 2);
        chk("t1_rd_dn", rd_dn, 4'b0001);
        chk("t1_rdata", rdata, 32'hDEAD_BEEF);
        step();
        chk("t1_rd_dn_gone", rd_dn, 4'b0000);

        // four held writers: round-robin order 0,1,2,3,0
        do_reset();
        for (int i = 0; i < N; i++)
            set_slot(i, 32'h100 + 32'(i * 4), 32'h1111_1111 * 32'(i + 1));
        auto_rel = 1'b0;
        req_wr = 4'b1111;
        last_g = '0; ng = 0; ndn = 0; cyc = 0;
        while (ng < 5 && cyc < 80) begin
            step();
            cyc++;
            if (wr_dn != '0) ndn++;
            if (gnt != '0 && gnt != last_g) begin
                g_seen[ng] = gnt; w_seen[ng] = mem_wdata; ng++;
            end
            last_g = gnt;
        end
        req_wr = '0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (wr_dn != '0) ndn++;
        end
        chk("t2_ngrants", ng, 5);
        for (int i = 0; i < 5; i++) begin
            chk("t2_gnt_order", g_seen[i], exp_g[i]);
            chk("t2_wdata", w_seen[i], exp_w[i]);
        end
        chk("t2_wr_dn_count", ndn, 5);
        auto_rel = 1'b1;

        // requester 2 asks for read and write together; address changes mid-access
        do_reset();
        set_slot(2, 32'h200, 32'h2222_0000);
        rd_val = 32'h3333_0002;
        req_rd[2] = 1'b1; req_wr[2] = 1'b1;
        step();
        chk("t3_gnt", gnt, 4'b0100);
        chk("t3_mem_rd", mem_rd, 1'b1);
        chk("t3_mem_wr", mem_wr, 1'b0);
        set_slot(2, 32'h204, 32'h2222_0004);
        step();
        chk("t3_addr_stable", mem_addr, 32'h200);
        wait_dn(cyc);
        chk("t3_rd_dn", rd_dn, 4'b0100);
        chk("t3_no_wr_dn", wr_dn, 4'b0000);
        chk("t3_rdata", rdata, 32'h3333_0002);
        cyc = 0;
        do begin step(); cyc++; end while (!mem_wr && cyc < 10);
        chk("t3_gnt2", gnt, 4'b0100);
        chk("t3_mem_wr2", mem_wr, 1'b1);
        chk("t3_addr2", mem_addr, 32'h204);
        wait_dn(cyc);
        chk("t3_wr_dn", wr_dn, 4'b0100);

        // timeout: no ack, TMO=4
        set_slot(1, 32'h110, 32'h0);
        rd_val = 32'hFFFF_FFFF;
        ack_en = 1'b0;
        req_rd[1] = 1'b1;
        done = 1'b0; nhigh = 0; cyc = 0;
        while (!done && cyc < 30) begin
            step();
            cyc++;
            if (mem_rd) nhigh++;
            if (rd_dn != '0) done = 1'b1;
        end
        chk("t4_strobe_cycles", nhigh, 4);
        chk("t4_rd_dn", rd_dn, 4'b0010);
        chk("t4_err", err, 1'b1);
        chk("t4_rdata_kept", rdata, 32'h3333_0002);
        ack_en = 1'b1;

        // reset in the second ACCESS cycle aborts the access
        do_reset();
        ack_en = 1'b0;
        req_rd[0] = 1'b1;
        step();
        step();
        rst = 1'b1; req_rd = '0;
        step();
        chk("t5_gnt", gnt, 4'b0000);
        chk("t5_mem_rd", mem_rd, 1'b0);
        chk("t5_busy", bus_busy, 1'b0);
        chk("t5_mem_addr", mem_addr, 32'h0);
        chk("t5_rd_dn", rd_dn, 4'b0000);
        rst = 1'b0; ack_en = 1'b1;
        req_rd[1] = 1'b1;
        step();
        chk("t5_gnt_next", gnt, 4'b0010);
        wait_dn(cyc);
        chk("t5_rd_dn_next", rd_dn, 4'b0010);

        // mixed traffic with slower memory, checked by the model every cycle
        for (int i = 0; i < N; i++)
            set_slot(i, 32'h4000 + 32'(i * 16), 32'hA5A5_0000 + 32'(i));
        ack_dly = 3;
        req_rd = 4'b1001; req_wr = 4'b0111;
        cyc = 0;
        while ((req_rd | req_wr) != '0 && cyc < 200) begin
            rd_val = rd_val + 32'h0101_0101;
            step();
            cyc++;
        end
        chk("t6_drained", (req_rd | req_wr) != '0, 1'b0);
        for (int c = 0; c < 4; c++) step();
        chk("t6_idle", bus_busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
